fetch_decode_buffer: RTL

- Fetch-to-decode pipeline stage that sits directly upstream of the sign extender.
- Accepts {PC, instruction} from fetch over a valid/ready handshake and buffers up to two entries (main plus skid) so fetch sees a registered ready.
- At capture, slices the instruction into opcode, register fields, funct fields and the 12-bit immediate field; the sign extender consumes the opcode and immediate outputs directly.
- Supports a synchronous pipeline flush for taken branches and jumps.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/instr_field_decode.sv | 34 +++
 rtl/fetch_decode_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, the buffered decode entry and immediate-field selection.
package rv_pkg;
  localparam int RV_XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] instr;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [11:0]        imm_value;
  } dec_entry_t;

  // B-type yields offset[12:1]; the sign extender appends the zero LSB.
  function automatic logic [11:0] imm_field_sel(input logic [6:0] op, input logic [31:0] instr);
    case (op)
      OP_STORE:  imm_field_sel = {instr[31:25], instr[11:7]};
      OP_BRANCH: imm_field_sel = {instr[31], instr[7], instr[30:25], instr[11:8]};
      default:   imm_field_sel = instr[31:20];
    endcase
  endfunction
endpackage

// File: rtl/instr_field_decode.sv
// Combinational slicing of a fetched instruction into a dec_entry_t.
// FETCH_DECODE_ILLEGAL_CHK_EN adds the o_illegal opcode check.
module instr_field_decode
  import rv_pkg::*;
(
  input  logic [RV_XLEN-1:0] i_pc,
  input  logic [RV_XLEN-1:0] i_instr,
`ifdef FETCH_DECODE_ILLEGAL_CHK_EN
  output logic               o_illegal,
`endif
  output dec_entry_t         o_entry
);
  logic [6:0] w_op;
  assign w_op = i_instr[6:0];

  always_comb begin
    o_entry           = '0;
    o_entry.pc        = i_pc;
    o_entry.instr     = i_instr;
    o_entry.opcode    = w_op;
    o_entry.rd        = i_instr[11:7];
    o_entry.rs1       = i_instr[19:15];
    o_entry.rs2       = i_instr[24:20];
    o_entry.funct3    = i_instr[14:12];
    o_entry.funct7    = i_instr[31:25];
    o_entry.imm_value = imm_field_sel(w_op, i_instr);
  end

`ifdef FETCH_DECODE_ILLEGAL_CHK_EN
  assign o_illegal = (i_instr[1:0] != 2'b11) ||
                     !(w_op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM});
`endif
endmodule

// File: rtl/fetch_decode_buffer.sv
// Two-entry (main + skid) fetch-to-decode buffer with registered in_ready, pre-decoded fields and flush.
// Optional illegal_op output enabled by FETCH_DECODE_ILLEGAL_CHK_EN.
module fetch_decode_buffer
  import rv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_VAL = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
`ifdef FETCH_DECODE_ILLEGAL_CHK_EN
  output logic            illegal_op,
`endif
  output logic [11:0]     imm_value
);
  dec_entry_t r_main, r_skid, w_dec;
  logic       r_main_v, r_skid_v, r_in_ready;
  logic       w_acc, w_pop;
  logic       w_main_v_nxt, w_skid_v_nxt, w_ld_main_in, w_ld_main_skid, w_ld_skid;

`ifdef FETCH_DECODE_ILLEGAL_CHK_EN
  logic w_ill, r_main_ill, r_skid_ill;
  instr_field_decode u_dec (.i_pc(in_pc), .i_instr(in_instr), .o_illegal(w_ill), .o_entry(w_dec));
`else
  instr_field_decode u_dec (.i_pc(in_pc), .i_instr(in_instr), .o_entry(w_dec));
`endif

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_main_v & out_ready;

  always_comb begin
    w_main_v_nxt   = r_main_v;
    w_skid_v_nxt   = r_skid_v;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (!r_main_v || (w_pop && !r_skid_v)) begin
      w_main_v_nxt = w_acc;
      w_ld_main_in = w_acc;
    end else if (!w_pop) begin
      // Main stalled: a new entry parks in skid.
      if (w_acc) begin
        w_skid_v_nxt = 1'b1;
        w_ld_skid    = 1'b1;
      end
    end else begin
      w_ld_main_skid = 1'b1;
      w_main_v_nxt   = 1'b1;
      w_skid_v_nxt   = w_acc;
      w_ld_skid      = w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
      r_main     <= '0;
      r_main.pc  <= RESET_PC_VAL;
      r_skid     <= '0;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_main_v   <= w_main_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= ~w_skid_v_nxt;
      if (w_ld_main_in)        r_main <= w_dec;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_dec;
    end
  end

`ifdef FETCH_DECODE_ILLEGAL_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else if (!flush) begin
      if (w_ld_main_in)        r_main_ill <= w_ill;
      else if (w_ld_main_skid) r_main_ill <= r_skid_ill;
      if (w_ld_skid)           r_skid_ill <= w_ill;
    end
  end
  assign illegal_op = r_main_ill;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign out_pc    = r_main.pc;
  assign out_instr = r_main.instr;
  assign opcode    = r_main.opcode;
  assign rd        = r_main.rd;
  assign rs1       = r_main.rs1;
  assign rs2       = r_main.rs2;
  assign funct3    = r_main.funct3;
  assign funct7    = r_main.funct7;
  assign imm_value = r_main.imm_value;
endmodule
